// File: rtl/core_mem_arbiter.sv
// Two-requester memory bus arbiter: fetch and load/store share one bus, one
// transaction in flight, data preferred with a starvation bound for fetch.
module core_mem_arbiter #(
    parameter int FETCH_STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic [29:0] addr,
    output logic        fetched,
    output logic [31:0] fetch_data,
    input  logic        data_start,
    input  logic        data_write,
    input  logic [29:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        mem_start,
    output logic        mem_write,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int CW = $clog2(FETCH_STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(FETCH_STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    typedef struct packed {
        logic        write;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

    state_t        state;
    logic [CW-1:0] starve;
    bus_req_t      bus;
    logic          arb, grant_fetch, grant_data;

    // A completing transaction is also an arbitration point, so the bus never idles.
    assign arb         = (state == IDLE) || mem_ready;
    assign grant_fetch = fetch && (!data_start || starve == LIMIT);
    assign grant_data  = data_start && !grant_fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            starve    <= '0;
            mem_start <= 1'b0;
            bus       <= '0;
        end else begin
            mem_start <= 1'b0;
            if (arb) begin
                if (grant_fetch) begin
                    state     <= FETCH;
                    mem_start <= 1'b1;
                    starve    <= '0;
                    bus       <= '{write: 1'b0, addr: addr, wdata: 32'h0, be: 4'hF};
                end else if (grant_data) begin
                    state     <= DATA;
                    mem_start <= 1'b1;
                    starve    <= fetch ? starve + 1'b1 : '0;
                    bus       <= '{write: data_write, addr: data_addr,
                                   wdata: data_wdata, be: data_be};
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    assign mem_write  = bus.write;
    assign mem_addr   = bus.addr;
    assign mem_wdata  = bus.wdata;
    assign mem_be     = bus.be;

    assign fetched    = (state == FETCH) && mem_ready;
    assign data_ready = (state == DATA) && mem_ready;
    assign fetch_data = mem_rdata;
    assign data_rdata = mem_rdata;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_core_mem_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        fetch = 0, data_start = 0, data_write = 0, mem_ready = 0;
    logic [29:0] addr = 0, data_addr = 0;
    logic [31:0] data_wdata = 0, mem_rdata = 0;
    logic [3:0]  data_be = 0;
    logic        fetched, data_ready, mem_start, mem_write;
    logic [31:0] fetch_data, data_rdata, mem_wdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;

    int checks = 0, errors = 0;

    core_mem_arbiter #(.FETCH_STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .addr(addr), .fetched(fetched),
        .fetch_data(fetch_data), .data_start(data_start), .data_write(data_write),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
        .data_ready(data_ready), .data_rdata(data_rdata), .mem_start(mem_start),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        f;  logic [29:0] fa;
        logic        d;  logic dw; logic [29:0] da; logic [31:0] wd; logic [3:0] be;
        logic [31:0] rd; int wt;
        logic        xf; logic [29:0] xa; logic xw; logic [31:0] xwd; logic [3:0] xbe;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        fetch = v.f; addr = v.fa; data_start = v.d; data_write = v.dw;
        data_addr = v.da; data_wdata = v.wd; data_be = v.be; mem_ready = 0;
        @(negedge clk);
        chk("vec start", mem_start, 1);
        chk("vec addr", mem_addr, v.xa);
        chk("vec write", mem_write, v.xw);
        chk("vec wdata", mem_wdata, v.xwd);
        chk("vec be", mem_be, v.xbe);
        fetch = 0; data_start = 0; addr = ~v.fa; data_addr = ~v.da;
        for (int i = 0; i < v.wt; i++) begin
            @(negedge clk);
            chk("vec no restart", mem_start, 0);
            chk("vec addr hold", mem_addr, v.xa);
        end
        mem_ready = 1; mem_rdata = v.rd;
        #1;
        chk("vec fetched", fetched, v.xf);
        chk("vec data_ready", data_ready, !v.xf);
        chk("vec fetch_data", fetch_data, v.rd);
        chk("vec data_rdata", data_rdata, v.rd);
        @(negedge clk);
        mem_ready = 0;
        chk("vec idle after", mem_start, 0);
        #1 chk("vec no resp idle", fetched | data_ready, 0);
    endtask

    // reference model state: owner of outstanding transaction and expected bus record
    typedef struct { logic w; logic [29:0] a; logic [31:0] wd; logic [3:0] be; } bus_t;
    int   m_own;        // 0 none, 1 fetch, 2 data
    int   m_streak;     // consecutive data wins while fetch waited
    logic m_start;
    bus_t m_bus;

    initial begin
        vecs.push_back('{1,30'h100,0,0,0,0,0,32'hDEADBEEF,1, 1,30'h100,0,0,4'hF});
        vecs.push_back('{0,0,1,1,30'h20,32'h12345678,4'b0011,32'h0,2, 0,30'h20,1,32'h12345678,4'b0011});
        vecs.push_back('{0,0,1,0,30'h3FFFFFFF,32'hAAAA5555,4'h0,32'h55,3, 0,30'h3FFFFFFF,0,32'hAAAA5555,4'h0});
        vecs.push_back('{1,30'h10,1,0,30'h44,32'h1,4'h1,32'hCAFE,1, 0,30'h44,0,32'h1,4'h1});
        vecs.push_back('{1,30'h10,1,1,30'h48,32'h2,4'h8,32'hF00D,1, 0,30'h48,1,32'h2,4'h8});
        vecs.push_back('{1,30'h3FFFFFFF,0,1,30'h9,32'h3,4'h2,32'h0BAD,2, 1,30'h3FFFFFFF,0,32'h0,4'hF});
        vecs.push_back('{1,30'h10,1,1,30'h4C,32'h4,4'hC,32'h7777,1, 0,30'h4C,1,32'h4,4'hC});

        // reset state
        mem_rdata = 32'h13579BDF;
        #1;
        chk("rst start", mem_start, 0);
        chk("rst write", mem_write, 0);
        chk("rst addr", mem_addr, 0);
        chk("rst wdata", mem_wdata, 0);
        chk("rst be", mem_be, 0);
        chk("rst fetched", fetched, 0);
        chk("rst data_ready", data_ready, 0);
        chk("rst fetch_data", fetch_data, 32'h13579BDF);
        chk("rst data_rdata", data_rdata, 32'h13579BDF);
        @(negedge clk); @(negedge clk);
        rst = 0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // spurious ready while idle
        @(negedge clk);
        mem_ready = 1;
        #1 chk("spur fetched", fetched, 0);
        chk("spur data_ready", data_ready, 0);
        @(negedge clk);
        chk("spur no start", mem_start, 0);
        mem_ready = 0;

        // fetch readdressed/dropped mid-transaction still completes as latched
        fetch = 1; addr = 30'hABC;
        @(negedge clk);
        chk("flush start", mem_start, 1);
        chk("flush addr", mem_addr, 30'hABC);
        fetch = 0; addr = 30'h111;
        @(negedge clk);
        chk("flush hold addr", mem_addr, 30'hABC);
        fetch = 1; addr = 30'h222;
        @(negedge clk);
        chk("flush no start", mem_start, 0);
        chk("flush hold addr2", mem_addr, 30'hABC);
        fetch = 0; mem_ready = 1;
        #1 chk("flush fetched", fetched, 1);
        @(negedge clk);
        mem_ready = 0;
        chk("flush idle", mem_start, 0);

        // back-to-back fetches, ready one cycle after each start
        fetch = 1; addr = 30'h55;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                chk("b2b start", mem_start, 1);
                chk("b2b addr", mem_addr, 30'h55);
                mem_ready = 0;
                #1 chk("b2b no resp", fetched, 0);
            end else begin
                chk("b2b gap", mem_start, 0);
                mem_ready = 1;
                if (i == 7) fetch = 0;
                #1 chk("b2b fetched", fetched, 1);
            end
        end
        @(negedge clk);
        mem_ready = 0;
        chk("b2b end idle", mem_start, 0);

        // sustained contention, zero-wait memory: D,D,D,D,F repeating
        fetch = 1; addr = 30'h111; data_start = 1; data_write = 1;
        data_addr = 30'h222; data_wdata = 32'h0; data_be = 4'hF; mem_ready = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("cont start", mem_start, 1);
            chk("cont addr", mem_addr, (i % 5 == 4) ? 30'h111 : 30'h222);
            #1 chk("cont fetched", fetched, (i % 5 == 4));
            chk("cont data_ready", data_ready, (i % 5 != 4));
            if (i == 14) begin fetch = 0; data_start = 0; end
        end
        @(negedge clk);
        mem_ready = 0;
        chk("cont idle", mem_start, 0);

        // reset in the middle of a data transaction
        data_start = 1; data_write = 1; data_addr = 30'h77; data_wdata = 32'hFFFF0000; data_be = 4'hA;
        @(negedge clk);
        chk("rmid start", mem_start, 1);
        data_start = 0; rst = 1;
        #1;
        chk("rmid start0", mem_start, 0);
        chk("rmid addr0", mem_addr, 0);
        chk("rmid write0", mem_write, 0);
        chk("rmid wdata0", mem_wdata, 0);
        chk("rmid be0", mem_be, 0);
        @(negedge clk);
        rst = 0; mem_ready = 1;
        #1 chk("rmid no data_ready", data_ready, 0);
        chk("rmid no fetched", fetched, 0);
        @(negedge clk);
        chk("rmid idle", mem_start, 0);
        mem_ready = 0;

        // randomized traffic against reference model (DUT idle, streak 0 here)
        m_own = 0; m_streak = 0; m_start = 0; m_bus = '{0, 0, 0, 0};
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            chk("rnd start", mem_start, m_start);
            if (m_start) begin
                chk("rnd addr", mem_addr, m_bus.a);
                chk("rnd write", mem_write, m_bus.w);
                chk("rnd wdata", mem_wdata, m_bus.wd);
                chk("rnd be", mem_be, m_bus.be);
            end
            fetch = ($urandom % 4) != 0;
            data_start = ($urandom % 4) != 0;
            addr = 30'($urandom); data_addr = 30'($urandom);
            data_write = 1'($urandom); data_wdata = $urandom; data_be = 4'($urandom);
            mem_rdata = $urandom;
            if (m_own != 0 && !m_start) mem_ready = ($urandom % 2) == 0;
            else mem_ready = ($urandom % 8) == 0;
            #1;
            chk("rnd fetched", fetched, (m_own == 1) && mem_ready);
            chk("rnd data_ready", data_ready, (m_own == 2) && mem_ready);
            chk("rnd rdata", data_rdata, mem_rdata);
            m_start = 0;
            if (m_own == 0 || mem_ready) begin
                if (fetch && (!data_start || m_streak == LIM)) begin
                    m_own = 1; m_start = 1; m_streak = 0;
                    m_bus = '{0, addr, 32'h0, 4'hF};
                end else if (data_start) begin
                    m_own = 2; m_start = 1;
                    m_streak = fetch ? m_streak + 1 : 0;
                    m_bus = '{data_write, data_addr, data_wdata, data_be};
                end else begin
                    m_own = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
